hazard_scoreboard_unit: RTL

//  Second-generation hazard controller. Adds a register scoreboard for variable-latency
//  ops (MUL/DIV, slow loads) that write back out of order. Keeps load-use stall and

---
 rtl/hazard_scoreboard_unit_if.sv | 45 ++++
 rtl/hazard_scoreboard_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit_if.sv
// Bundle of pipeline-side signals seen by the hazard scoreboard unit.
// The slave modport is the hazard unit; the master modport is the pipeline/driver.
interface hazard_scoreboard_unit_if #(
    parameter int REG_AW      = 5,
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = 32
);
    localparam int PCNT_W = $clog2(MAX_PENDING + 1);

    logic [REG_AW-1:0] i_rs1_d;
    logic [REG_AW-1:0] i_rs2_d;
    logic [REG_AW-1:0] i_rd_d;
    logic              i_lc_op_d;
    logic              i_lc_issue_e;
    logic [REG_AW-1:0] i_rd_e;
    logic              i_res_src_b0_e;
    logic              i_lc_done;
    logic [REG_AW-1:0] i_lc_done_rd;
    logic [1:0]        i_pc_src_e;
    logic              i_jmp_e;
    logic              i_mret_e;

    logic              o_pc_stall;
    logic              o_if_id_stall;
    logic              o_if_id_flush;
    logic              o_id_ex_flush;
    logic [PCNT_W-1:0] o_pending_cnt;
    logic              o_sb_err;
    logic [CNT_W-1:0]  o_stall_cycles;
    logic [CNT_W-1:0]  o_flush_events;

    modport slave (
        input  i_rs1_d, i_rs2_d, i_rd_d, i_lc_op_d, i_lc_issue_e, i_rd_e,
               i_res_src_b0_e, i_lc_done, i_lc_done_rd, i_pc_src_e, i_jmp_e, i_mret_e,
        output o_pc_stall, o_if_id_stall, o_if_id_flush, o_id_ex_flush,
               o_pending_cnt, o_sb_err, o_stall_cycles, o_flush_events
    );

    modport master (
        output i_rs1_d, i_rs2_d, i_rd_d, i_lc_op_d, i_lc_issue_e, i_rd_e,
               i_res_src_b0_e, i_lc_done, i_lc_done_rd, i_pc_src_e, i_jmp_e, i_mret_e,
        input  o_pc_stall, o_if_id_stall, o_if_id_flush, o_id_ex_flush,
               o_pending_cnt, o_sb_err, o_stall_cycles, o_flush_events
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Hazard controller with an out-of-order writeback scoreboard, load-use stall and
// redirect flush. Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_scoreboard_unit #(
    parameter int REG_AW      = 5,
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    hazard_scoreboard_unit_if.slave  hz
);
    localparam int NREG   = 2 ** REG_AW;
    localparam int PCNT_W = $clog2(MAX_PENDING + 1);
    localparam logic [PCNT_W-1:0] CNT_MAX = PCNT_W'(MAX_PENDING);
    localparam logic [PCNT_W-1:0] CNT_ONE = PCNT_W'(1);

    logic [NREG-1:0]   busy_q, busy_d;
    logic [PCNT_W-1:0] cnt_q, cnt_d;
    logic              sb_err_q, sb_err_d;

    logic [NREG-1:0]   done_mask;
    logic [NREG-1:0]   issue_mask;
    logic [NREG-1:0]   busy_eff;
    logic              issue_act;
    logic              done_hit;
    logic              full_eff;
    logic              cnt_inc;
    logic              overflow;
    logic              src1_busy, src2_busy, dst_busy;
    logic              sb_stall;
    logic              lu_stall;
    logic              redirect;
    logic              stall;
    logic              pc_stall, if_id_stall, if_id_flush, id_ex_flush;

    assign issue_act = hz.i_lc_issue_e && (hz.i_rd_e != '0);
    assign done_hit  = hz.i_lc_done && busy_q[hz.i_lc_done_rd];

    always_comb begin
        done_mask  = '0;
        issue_mask = '0;
        if (hz.i_lc_done) done_mask[hz.i_lc_done_rd] = 1'b1;
        if (issue_act)    issue_mask[hz.i_rd_e]      = 1'b1;
    end

    // A result retiring this cycle is forwarded by WB, so it neither blocks its
    // consumer nor counts against the outstanding-op limit.
    assign busy_eff = busy_q & ~done_mask;
    assign full_eff = (cnt_q == CNT_MAX) && !done_hit;

    assign src1_busy = (hz.i_rs1_d != '0) && busy_eff[hz.i_rs1_d];
    assign src2_busy = (hz.i_rs2_d != '0) && busy_eff[hz.i_rs2_d];
    assign dst_busy  = (hz.i_rd_d  != '0) && busy_eff[hz.i_rd_d];

    assign sb_stall = src1_busy || src2_busy || dst_busy || (hz.i_lc_op_d && full_eff);

    assign lu_stall = hz.i_res_src_b0_e && (hz.i_rd_e != '0) &&
                      (((hz.i_rs1_d != '0) && (hz.i_rs1_d == hz.i_rd_e)) ||
                       ((hz.i_rs2_d != '0) && (hz.i_rs2_d == hz.i_rd_e)));

    assign redirect = (hz.i_pc_src_e == 2'b01) || hz.i_jmp_e || hz.i_mret_e;
    assign stall    = sb_stall || lu_stall;

    always_comb begin
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (!i_rst) begin
            if (redirect) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (stall) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    // Issuing into a full scoreboard is illegal; the count saturates and the error sticks.
    assign cnt_inc  = issue_act && !full_eff;
    assign overflow = issue_act && full_eff;

    always_comb begin
        busy_d = busy_eff | issue_mask;
        busy_d[0] = 1'b0;
        cnt_d = cnt_q;
        if (cnt_inc && !done_hit)      cnt_d = cnt_q + CNT_ONE;
        else if (!cnt_inc && done_hit) cnt_d = cnt_q - CNT_ONE;
        sb_err_d = sb_err_q || (hz.i_lc_done && !done_hit) || overflow;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_q   <= '0;
            cnt_q    <= '0;
            sb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (stall && !redirect && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        if (redirect && (flush_events_q != '1))
            flush_events_d = flush_events_q + CNT_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign hz.o_stall_cycles = stall_cycles_q;
    assign hz.o_flush_events = flush_events_q;
`else
    assign hz.o_stall_cycles = '0;
    assign hz.o_flush_events = '0;
`endif

    assign hz.o_pc_stall    = pc_stall;
    assign hz.o_if_id_stall = if_id_stall;
    assign hz.o_if_id_flush = if_id_flush;
    assign hz.o_id_ex_flush = id_ex_flush;
    assign hz.o_pending_cnt = cnt_q;
    assign hz.o_sb_err      = sb_err_q;
endmodule
